// File: rtl/seg7_scan_driver.sv
// Eight-digit multiplexed seven-segment driver with frame-coherent display updates
// and optional leading-zero blanking.
module seg7_scan_driver #(
    parameter int CLK_DIV  = 100000,
    parameter int BLANK_LZ = 0
) (
    input  logic        clk_100,
    input  logic        reset,
    input  logic [31:0] data_in,
    input  logic [7:0]  dp_in,
    input  logic        data_valid,
    input  logic        blank,
    output logic        pending,
    output logic        CA,
    output logic        CB,
    output logic        CC,
    output logic        CD,
    output logic        CE,
    output logic        CF,
    output logic        CG,
    output logic        DP,
    output logic [7:0]  AN
);

    localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_DIV - 1);

    logic [PRE_W-1:0] pre_cnt;
    logic [2:0]       idx;
    logic             tick;
    logic             frame_end;
    logic [31:0]      pend_data;
    logic [7:0]       pend_dp;
    logic [31:0]      disp_data;
    logic [7:0]       disp_dp;
    logic             live_p0;
    logic [7:0]       an_nxt;
    logic [6:0]       seg_nxt;
    logic             dp_nxt;

    function automatic logic [6:0] seg_encode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    // Digit i is a leading zero when it and every digit to its left carry no nibble and no dp.
    function automatic logic lz_dark(input logic [31:0] d, input logic [7:0] p, input logic [2:0] i);
        logic dark;
        dark = (i != 3'd0);
        for (int k = 0; k < 8; k++) begin
            if (k >= int'(i) && (d[4*k +: 4] != 4'h0 || p[k]))
                dark = 1'b0;
        end
        return dark;
    endfunction

    assign tick      = (pre_cnt == PRE_MAX);
    assign frame_end = tick && (idx == 3'd7);

    always_ff @(posedge clk_100 or negedge reset) begin
        if (!reset) begin
            pre_cnt <= '0;
            idx     <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
            idx     <= idx + 3'd1;
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

    // A strobe on the boundary bypasses the pending register entirely.
    always_ff @(posedge clk_100 or negedge reset) begin
        if (!reset) begin
            pend_data <= '0;
            pend_dp   <= '0;
            disp_data <= '0;
            disp_dp   <= '0;
            pending   <= 1'b0;
        end else if (data_valid) begin
            if (frame_end) begin
                disp_data <= data_in;
                disp_dp   <= dp_in;
                pending   <= 1'b0;
            end else begin
                pend_data <= data_in;
                pend_dp   <= dp_in;
                pending   <= 1'b1;
            end
        end else if (frame_end && pending) begin
            disp_data <= pend_data;
            disp_dp   <= pend_dp;
            pending   <= 1'b0;
        end
    end

    always_comb begin
        an_nxt  = 8'hFF;
        seg_nxt = seg_encode(disp_data[{idx, 2'b00} +: 4]);
        dp_nxt  = ~disp_dp[idx];
        if (live_p0 && !blank && !(BLANK_LZ != 0 && lz_dark(disp_data, disp_dp, idx)))
            an_nxt = ~(8'd1 << idx);
        if (!live_p0) begin
            seg_nxt = 7'h7F;
            dp_nxt  = 1'b1;
        end
    end

    // Output register stage: live_p0 holds the drive dark for the first edge after reset.
    always_ff @(posedge clk_100 or negedge reset) begin
        if (!reset) begin
            live_p0                  <= 1'b0;
            AN                       <= 8'hFF;
            {CA, CB, CC, CD, CE, CF, CG} <= 7'h7F;
            DP                       <= 1'b1;
        end else begin
            live_p0                  <= 1'b1;
            AN                       <= an_nxt;
            {CA, CB, CC, CD, CE, CF, CG} <= seg_nxt;
            DP                       <= dp_nxt;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver at CLK_DIV=4, with a second leading-zero-blanking instance.
module tb_seg7_scan_driver;

    logic        clk_100 = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] data_in = '0;
    logic [7:0]  dp_in = '0;
    logic        data_valid = 1'b0;
    logic        blank = 1'b0;

    logic        pending, CA, CB, CC, CD, CE, CF, CG, DP;
    logic [7:0]  AN;
    logic        pending_lz, CA_lz, CB_lz, CC_lz, CD_lz, CE_lz, CF_lz, CG_lz, DP_lz;
    logic [7:0]  AN_lz;
    logic [6:0]  segs;

    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;
    int n_fail = 0;

    always #5 clk_100 = ~clk_100;
    assign segs = {CA, CB, CC, CD, CE, CF, CG};

    seg7_scan_driver #(.CLK_DIV(4), .BLANK_LZ(0)) dut (
        .clk_100(clk_100), .reset(reset), .data_in(data_in), .dp_in(dp_in),
        .data_valid(data_valid), .blank(blank), .pending(pending),
        .CA(CA), .CB(CB), .CC(CC), .CD(CD), .CE(CE), .CF(CF), .CG(CG), .DP(DP), .AN(AN)
    );

    seg7_scan_driver #(.CLK_DIV(4), .BLANK_LZ(1)) dut_lz (
        .clk_100(clk_100), .reset(reset), .data_in(data_in), .dp_in(dp_in),
        .data_valid(data_valid), .blank(blank), .pending(pending_lz),
        .CA(CA_lz), .CB(CB_lz), .CC(CC_lz), .CD(CD_lz), .CE(CE_lz), .CF(CF_lz), .CG(CG_lz),
        .DP(DP_lz), .AN(AN_lz)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Advance to just after edge n counted from reset release.
    task automatic to_edge(input int n);
        while (cyc < n) begin
            @(posedge clk_100);
            cyc++;
        end
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 reset = 1'b0;
        #1;
        check("rst_an", AN, 8'hFF);
        check("rst_seg", segs, 7'h7F);
        check("rst_dp", DP, 1'b1);
        check("rst_pend", pending, 1'b0);
        repeat (2) @(posedge clk_100);
        #1 reset = 1'b1;
        cyc = 0;

        to_edge(1);   check("dark_e1", AN, 8'hFF);
        to_edge(2);   check("idle_an0", AN, 8'hFE);
        check("idle_seg0", segs, 7'b0000001);
        check("idle_dp0", DP, 1'b1);
        check("lz_d0_zero", AN_lz, 8'hFE);
        to_edge(4);   check("idle_an0_end", AN, 8'hFE);
        to_edge(5);   check("idle_an1", AN, 8'hFD);
        to_edge(9);   check("idle_an2", AN, 8'hFB);
        to_edge(29);  check("idle_an7", AN, 8'h7F);
        check("idle_seg7", segs, 7'b0000001);
        to_edge(33);  check("idle_wrap", AN, 8'hFE);

        to_edge(40);
        data_in = 32'h89ABCDEF; dp_in = 8'h01; data_valid = 1'b1;
        to_edge(41);
        data_valid = 1'b0;
        check("mid_pend", pending, 1'b1);
        to_edge(45);  check("mid_an3", AN, 8'hF7);
        check("mid_notear", segs, 7'b0000001);
        to_edge(63);  check("mid_pend_hold", pending, 1'b1);
        check("mid_old_d7", segs, 7'b0000001);
        to_edge(64);  check("mid_pend_clr", pending, 1'b0);
        to_edge(65);  check("new_an0", AN, 8'hFE);
        check("new_d0_F", segs, 7'b0111000);
        check("new_dp0", DP, 1'b0);
        to_edge(69);  check("new_d1_E", segs, 7'b0110000);
        check("new_dp1", DP, 1'b1);
        to_edge(93);  check("new_an7", AN, 8'h7F);
        check("new_d7_8", segs, 7'b0000000);

        to_edge(100);
        data_in = 32'h11111111; dp_in = 8'h00; data_valid = 1'b1;
        to_edge(101); data_valid = 1'b0;
        to_edge(110);
        data_in = 32'h22222222; data_valid = 1'b1;
        to_edge(111); data_valid = 1'b0;
        check("last_pend", pending, 1'b1);
        for (int k = 0; k < 8; k++) begin
            to_edge(129 + 4 * k);
            check($sformatf("last_an%0d", k), AN, ~(32'd1 << k) & 32'hFF);
            check($sformatf("last_seg%0d", k), segs, 7'b0010010);
        end

        to_edge(159); check("bnd_pre", pending, 1'b0);
        data_in = 32'h00000007; dp_in = 8'h00; data_valid = 1'b1;
        to_edge(160); data_valid = 1'b0;
        check("bnd_pend", pending, 1'b0);
        to_edge(161); check("bnd_an0", AN, 8'hFE);
        check("bnd_d0_7", segs, 7'b0001111);
        to_edge(165); check("bnd_an1", AN, 8'hFD);
        check("bnd_d1_0", segs, 7'b0000001);
        check("lz_7_d1", AN_lz, 8'hFF);

        to_edge(170); blank = 1'b1;
        to_edge(171); check("blank_an", AN, 8'hFF);
        check("blank_an_lz", AN_lz, 8'hFF);
        to_edge(172);
        data_in = 32'h00000A30; dp_in = 8'h00; data_valid = 1'b1;
        to_edge(173); data_valid = 1'b0;
        check("blank_pend", pending, 1'b1);
        to_edge(180); blank = 1'b0;
        to_edge(181); check("unblank_an5", AN, 8'hDF);
        to_edge(192); check("blank_load", pending, 1'b0);

        to_edge(193); check("lz_an0", AN_lz, 8'hFE);
        check("lz_d0_0", segs, 7'b0000001);
        to_edge(197); check("lz_an1", AN_lz, 8'hFD);
        check("lz_d1_3", segs, 7'b0000110);
        to_edge(201); check("lz_an2", AN_lz, 8'hFB);
        check("lz_d2_A", segs, 7'b0001000);
        to_edge(205); check("lz_an3", AN_lz, 8'hFF);
        to_edge(221); check("lz_an7", AN_lz, 8'hFF);
        check("nolz_an7", AN, 8'h7F);

        to_edge(226);
        data_in = 32'hFFFFFFFF; dp_in = 8'hFF; data_valid = 1'b1;
        to_edge(227); data_valid = 1'b0;
        check("arst_pre_pend", pending, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("arst_an", AN, 8'hFF);
        check("arst_seg", segs, 7'h7F);
        check("arst_dp", DP, 1'b1);
        check("arst_pend", pending, 1'b0);
        check("arst_an_lz", AN_lz, 8'hFF);
        repeat (2) @(posedge clk_100);
        #1 reset = 1'b1;
        cyc = 0;
        to_edge(1);   check("rel_pend", pending, 1'b0);
        check("rel_dark", AN, 8'hFF);
        to_edge(2);   check("rel_an0", AN, 8'hFE);
        check("rel_seg0", segs, 7'b0000001);
        to_edge(33);  check("rel_f2_seg0", segs, 7'b0000001);
        check("rel_f2_dp0", DP, 1'b1);
        to_edge(37);  check("rel_f2_an1", AN, 8'hFD);
        check("rel_f2_seg1", segs, 7'b0000001);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
